// File: rtl/ballot_pkg.sv
// Shared types and bit positions for the ballot console.
// The console's uo_out feeds the voting machine's ui_in directly.
package ballot_pkg;

    typedef enum logic [2:0] {
        ST_CLEAR,
        ST_IDLE,
        ST_ARMED,
        ST_SETUP,
        ST_STROBE,
        ST_HOLD
    } state_e;

    typedef enum logic [1:0] {
        MODE_VOTE  = 2'b00,
        MODE_COUNT = 2'b01,
        MODE_RESET = 2'b10,
        MODE_TEST  = 2'b11
    } mode_e;

    // ui_in positions
    localparam int UI_CAST     = 4;
    localparam int UI_AUTH     = 5;
    localparam int UI_MODE_LSB = 6;

    // uo_out positions
    localparam int UO_CONFIRM  = 4;
    localparam int UO_CLEAR    = 5;
    localparam int UO_MODE_LSB = 6;

    // uio_out positions
    localparam int UIO_ARMED   = 0;
    localparam int UIO_BUSY    = 1;
    localparam int UIO_ERR     = 2;
    localparam int UIO_CNT_LSB = 3;

    function automatic logic is_onehot4(input logic [3:0] v);
        return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
    endfunction

    function automatic int max_of(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/tt_um_ballot_console_if.sv
// Tile pin bundle; master drives the buttons, slave is the console.
interface tt_um_ballot_console_if;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uo_out;
    logic [7:0] uio_in;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    modport master (output ena, ui_in, uio_in, input uo_out, uio_out, uio_oe);
    modport slave  (input ena, ui_in, uio_in, output uo_out, uio_out, uio_oe);
endinterface

// File: rtl/btn_conditioner.sv
// 2-FF synchronizer, debounce and rising-edge detect for a W-bit button group.
// A new value must be seen for DEB_CYC consecutive cycles before it is accepted.
module btn_conditioner #(
    parameter int W       = 1,
    parameter int DEB_CYC = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] raw_i,
    output logic [W-1:0] level_o,
    output logic [W-1:0] rise_o
);
    localparam int CW = $clog2(DEB_CYC + 1);

    logic [W-1:0]  meta_q, sync_q, cand_q, level_q, level_dly_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] run_d;

    // Length of the current run of an unchanged synchronized value.
    always_comb begin
        run_d = (sync_q == cand_q) ? cnt_q + 1'b1 : CW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q      <= '0;
            sync_q      <= '0;
            cand_q      <= '0;
            level_q     <= '0;
            level_dly_q <= '0;
            cnt_q       <= '0;
        end else begin
            meta_q      <= raw_i;
            sync_q      <= meta_q;
            cand_q      <= sync_q;
            level_dly_q <= level_q;
            if (sync_q == level_q) begin
                cnt_q <= '0;
            end else if (run_d >= CW'(DEB_CYC)) begin
                level_q <= sync_q;
                cnt_q   <= '0;
            end else begin
                cnt_q <= run_d;
            end
        end
    end

    assign level_o = level_q;
    assign rise_o  = level_q & ~level_dly_q;

endmodule

// File: rtl/tt_um_ballot_console.sv
// Voter-side console: turns raw buttons into a one-hot bus with a timed confirm
// strobe, issues the post-reset clear pulse and freezes mode during a ballot.
module tt_um_ballot_console
    import ballot_pkg::*;
#(
    parameter int DEB_CYC    = 8,
    parameter int SETUP_CYC  = 2,
    parameter int STROBE_CYC = 3,
    parameter int HOLD_CYC   = 2,
    parameter int CLR_CYC    = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    tt_um_ballot_console_if.slave        io
);
    localparam int PMAX = max_of(max_of(SETUP_CYC, STROBE_CYC), max_of(HOLD_CYC, CLR_CYC));
    localparam int PW   = $clog2(PMAX + 1);

    logic [5:0] btn_lvl, btn_rise;
    logic [1:0] mode_lvl, mode_rise;

    for (genvar gi = 0; gi < 6; gi++) begin : g_btn
        btn_conditioner #(.W(1), .DEB_CYC(DEB_CYC)) u_btn (
            .clk     (clk),
            .rst_n   (rst_n),
            .raw_i   (io.ui_in[gi]),
            .level_o (btn_lvl[gi]),
            .rise_o  (btn_rise[gi])
        );
    end

    btn_conditioner #(.W(2), .DEB_CYC(DEB_CYC)) u_mode (
        .clk     (clk),
        .rst_n   (rst_n),
        .raw_i   (io.ui_in[UI_MODE_LSB +: 2]),
        .level_o (mode_lvl),
        .rise_o  (mode_rise)
    );

    state_e        state_q;
    logic [PW-1:0] phase_q;
    logic [3:0]    voter_q;
    logic          confirm_q, clear_q, armed_q, busy_q, err_q;
    mode_e         mode_q;
    logic [4:0]    count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_CLEAR;
            phase_q   <= '0;
            voter_q   <= '0;
            confirm_q <= 1'b0;
            clear_q   <= 1'b1;
            mode_q    <= MODE_VOTE;
            armed_q   <= 1'b0;
            busy_q    <= 1'b0;
            err_q     <= 1'b0;
            count_q   <= '0;
        end else begin
            case (state_q)
                ST_CLEAR: begin
                    if (phase_q == PW'(CLR_CYC - 1)) begin
                        state_q <= ST_IDLE;
                        clear_q <= 1'b0;
                        phase_q <= '0;
                    end else begin
                        phase_q <= phase_q + 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (btn_rise[UI_AUTH]) begin
                        state_q <= ST_ARMED;
                        mode_q  <= MODE_VOTE;
                        armed_q <= 1'b1;
                        phase_q <= '0;
                    end else begin
                        mode_q <= mode_e'(mode_lvl);
                    end
                end
                ST_ARMED: begin
                    // Authorize again cancels; it wins over a simultaneous cast.
                    if (btn_rise[UI_AUTH]) begin
                        state_q <= ST_IDLE;
                        armed_q <= 1'b0;
                        phase_q <= '0;
                    end else if (btn_rise[UI_CAST]) begin
                        if (is_onehot4(btn_lvl[3:0])) begin
                            voter_q <= btn_lvl[3:0];
                            err_q   <= 1'b0;
                            busy_q  <= 1'b1;
                            state_q <= ST_SETUP;
                            phase_q <= '0;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                ST_SETUP: begin
                    if (phase_q == PW'(SETUP_CYC - 1)) begin
                        state_q   <= ST_STROBE;
                        confirm_q <= 1'b1;
                        phase_q   <= '0;
                    end else begin
                        phase_q <= phase_q + 1'b1;
                    end
                end
                ST_STROBE: begin
                    if (phase_q == PW'(STROBE_CYC - 1)) begin
                        state_q   <= ST_HOLD;
                        confirm_q <= 1'b0;
                        phase_q   <= '0;
                    end else begin
                        phase_q <= phase_q + 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (phase_q == PW'(HOLD_CYC - 1)) begin
                        state_q <= ST_IDLE;
                        voter_q <= '0;
                        count_q <= count_q + 5'd1;
                        armed_q <= 1'b0;
                        busy_q  <= 1'b0;
                        phase_q <= '0;
                    end else begin
                        phase_q <= phase_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_CLEAR;
                    clear_q <= 1'b1;
                    phase_q <= '0;
                end
            endcase
        end
    end

    assign io.uo_out  = {mode_q, clear_q, confirm_q, voter_q};
    assign io.uio_out = {count_q, err_q, busy_q, armed_q};
    assign io.uio_oe  = 8'hFF;

    logic unused_ok;
    assign unused_ok = ^{io.ena, io.uio_in, btn_lvl[UI_CAST], btn_lvl[UI_AUTH],
                         btn_rise[3:0], mode_rise};

endmodule

// File: tb/tb_tt_um_ballot_console.sv
// Directed bench for the ballot console: table of selections plus sequences
// for clear pulse, debounce boundary, mode freeze, reset mid-strobe and wrap.
module tb_tt_um_ballot_console;
    import ballot_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    tt_um_ballot_console_if io();

    tt_um_ballot_console #(
        .DEB_CYC    (4),
        .SETUP_CYC  (2),
        .STROBE_CYC (3),
        .HOLD_CYC   (2),
        .CLR_CYC    (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (io.slave)
    );

    typedef struct {
        logic [3:0] btn;
        logic       valid;
        logic [3:0] onehot;
        logic       mode_req;
    } vec_t;

    vec_t vecs[8];
    int   n_vec = 0;
    int   n_bad = 0;
    int   conf_pulses = 0;
    logic conf_prev = 1'b0;
    logic [4:0] exp_cnt = 5'd0;

    always @(negedge clk) begin
        if (io.uo_out[UO_CONFIRM] && !conf_prev) conf_pulses <= conf_pulses + 1;
        conf_prev <= io.uo_out[UO_CONFIRM];
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press_auth();
        io.ui_in[UI_AUTH] = 1'b1;
        tick(10);
        io.ui_in[UI_AUTH] = 1'b0;
        tick(10);
    endtask

    task automatic press_cast();
        io.ui_in[UI_CAST] = 1'b1;
        tick(10);
        io.ui_in[UI_CAST] = 1'b0;
        tick(10);
    endtask

    task automatic check_clear_pulse();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("clear_cyc%0d", i), io.uo_out[UO_CLEAR], (i < 4) ? 1 : 0);
        end
        chk("post_clear_voter_conf", io.uo_out[4:0], 0);
        chk("post_clear_uio", io.uio_out, 0);
    endtask

    task automatic cast_and_capture(input logic [3:0] exp_v, input logic [4:0] cnt, input bit mode_req);
        int waited;
        int pulses0;
        waited  = 0;
        pulses0 = conf_pulses;
        io.ui_in[UI_CAST] = 1'b1;
        while (io.uo_out[3:0] == 4'd0 && waited < 30) begin
            @(negedge clk);
            waited++;
        end
        chk("setup_seen", (waited < 30) ? 1 : 0, 1);
        for (int k = 0; k < 7; k++) begin
            chk($sformatf("voter_k%0d", k), io.uo_out[3:0], exp_v);
            chk($sformatf("confirm_k%0d", k), io.uo_out[UO_CONFIRM], (k >= 2 && k < 5) ? 1 : 0);
            chk($sformatf("mode_locked_k%0d", k), io.uo_out[7:6], 0);
            chk($sformatf("busy_k%0d", k), io.uio_out[UIO_BUSY], 1);
            if (mode_req && k == 2) io.ui_in[7:6] = 2'b11;
            @(negedge clk);
        end
        chk("voter_released", io.uo_out[3:0], 0);
        chk("ballot_count", io.uio_out[7:3], cnt);
        chk("armed_done", io.uio_out[UIO_ARMED], 0);
        chk("busy_done", io.uio_out[UIO_BUSY], 0);
        chk("err_clear", io.uio_out[UIO_ERR], 0);
        io.ui_in[UI_CAST] = 1'b0;
        tick(10);
        chk("one_pulse", conf_pulses - pulses0, 1);
    endtask

    initial begin
        bit   bench_armed;
        bit   seen;
        int   waited;
        int   pulses0;

        vecs[0] = '{4'b0100, 1'b1, 4'b0100, 1'b0};
        vecs[1] = '{4'b0110, 1'b0, 4'b0000, 1'b0};
        vecs[2] = '{4'b0001, 1'b1, 4'b0001, 1'b0};
        vecs[3] = '{4'b0000, 1'b0, 4'b0000, 1'b0};
        vecs[4] = '{4'b0010, 1'b1, 4'b0010, 1'b1};
        vecs[5] = '{4'b1111, 1'b0, 4'b0000, 1'b0};
        vecs[6] = '{4'b1000, 1'b1, 4'b1000, 1'b0};
        vecs[7] = '{4'b1001, 1'b0, 4'b0000, 1'b0};

        io.ena    = 1'b1;
        io.uio_in = 8'h00;
        io.ui_in  = 8'h40;
        rst_n     = 1'b0;
        tick(3);
        chk("reset_uo", io.uo_out, 8'h20);
        chk("reset_uio", io.uio_out, 0);
        chk("uio_oe", io.uio_oe, 8'hFF);
        @(posedge clk);
        #1 rst_n = 1'b1;
        check_clear_pulse();
        tick(6);
        chk("mode_follows_01", io.uo_out[7:6], 2'b01);

        // Debounce boundary: 3-cycle glitch rejected, 4 stable cycles accepted.
        io.ui_in[7:6] = 2'b10;
        tick(3);
        io.ui_in[7:6] = 2'b01;
        seen = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (io.uo_out[7:6] == 2'b10) seen = 1'b1;
        end
        chk("glitch3_rejected", seen, 0);
        io.ui_in[7:6] = 2'b10;
        tick(4);
        io.ui_in[7:6] = 2'b01;
        seen = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (io.uo_out[7:6] == 2'b10) seen = 1'b1;
        end
        chk("stable4_accepted", seen, 1);
        chk("mode_back_01", io.uo_out[7:6], 2'b01);

        // Cast without authorization does nothing.
        io.ui_in[3:0] = 4'b0100;
        tick(10);
        pulses0 = conf_pulses;
        press_cast();
        chk("noauth_pulses", conf_pulses - pulses0, 0);
        chk("noauth_armed", io.uio_out[UIO_ARMED], 0);
        chk("noauth_count", io.uio_out[7:3], 0);

        bench_armed = 1'b0;
        for (int v = 0; v < 8; v++) begin
            if (!bench_armed) begin
                press_auth();
                chk($sformatf("v%0d_armed", v), io.uio_out[UIO_ARMED], 1);
                chk($sformatf("v%0d_mode00", v), io.uo_out[7:6], 0);
                bench_armed = 1'b1;
            end
            io.ui_in[3:0] = vecs[v].btn;
            tick(10);
            if (vecs[v].valid) begin
                exp_cnt = exp_cnt + 5'd1;
                cast_and_capture(vecs[v].onehot, exp_cnt, vecs[v].mode_req);
                bench_armed = 1'b0;
                pulses0 = conf_pulses;
                press_cast();
                chk($sformatf("v%0d_second_cast", v), conf_pulses - pulses0, 0);
                if (vecs[v].mode_req) begin
                    chk("mode_applied_in_idle", io.uo_out[7:6], 2'b11);
                    io.ui_in[7:6] = 2'b01;
                    tick(10);
                end
            end else begin
                pulses0 = conf_pulses;
                press_cast();
                chk($sformatf("v%0d_select_err", v), io.uio_out[UIO_ERR], 1);
                chk($sformatf("v%0d_still_armed", v), io.uio_out[UIO_ARMED], 1);
                chk($sformatf("v%0d_no_voter", v), io.uo_out[3:0], 0);
                chk($sformatf("v%0d_no_pulse", v), conf_pulses - pulses0, 0);
            end
        end
        press_auth();
        chk("cancel_disarms", io.uio_out[UIO_ARMED], 0);
        chk("cancel_count", io.uio_out[7:3], exp_cnt);

        // Reset asserted in the middle of the strobe.
        press_auth();
        io.ui_in[3:0] = 4'b0010;
        tick(10);
        io.ui_in[UI_CAST] = 1'b1;
        waited = 0;
        while (!io.uo_out[UO_CONFIRM] && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        chk("confirm_reached", (waited < 40) ? 1 : 0, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_confirm_low", io.uo_out[UO_CONFIRM], 0);
        chk("rst_voter_low", io.uo_out[3:0], 0);
        chk("rst_clear_high", io.uo_out[UO_CLEAR], 1);
        chk("rst_count_zero", io.uio_out[7:3], 0);
        io.ui_in[UI_CAST] = 1'b0;
        tick(2);
        @(posedge clk);
        #1 rst_n = 1'b1;
        check_clear_pulse();
        tick(10);

        // 32 ballots wrap the counter back to zero.
        io.ui_in[3:0] = 4'b1000;
        exp_cnt = 5'd0;
        for (int b = 0; b < 32; b++) begin
            press_auth();
            exp_cnt = exp_cnt + 5'd1;
            cast_and_capture(4'b1000, exp_cnt, 1'b0);
        end
        chk("count_wrapped", io.uio_out[7:3], 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
